// File: rtl/traffic_ctrl_param.sv
// Two-road intersection controller driven by a 1 Hz tick strobe.
// Main/side phases with all-red clearance, gap-out, ped latch, night flash and BCD countdown.
module traffic_ctrl_param #(
    parameter int MAIN_MIN_T = 60,
    parameter int SIDE_MAX_T = 30,
    parameter int YELLOW_T   = 3,
    parameter int ALL_RED_T  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       is_car,
    input  logic       ped_req,
    input  logic       night,
    output logic [5:0] LEDR,
    output logic [3:0] num1,
    output logic [3:0] num0,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        ARA = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        ARB = 3'd5,
        FL  = 3'd6
    } state_t;

    localparam logic [6:0] MAIN_L = 7'(MAIN_MIN_T);
    localparam logic [6:0] SIDE_L = 7'(SIDE_MAX_T);
    localparam logic [6:0] YEL_L  = 7'(YELLOW_T);
    localparam logic [6:0] RED_L  = 7'(ALL_RED_T);

    state_t     state, state_n;
    logic [6:0] rem, rem_n;
    logic       ped, ped_n;
    logic       phase, phase_n;

    function automatic logic [5:0] lamps(state_t s, logic ph);
        logic [5:0] l;
        l = 6'b100100;
        unique case (s)
            MG:      l = 6'b010100;
            MY:      l = 6'b001100;
            SG:      l = 6'b100010;
            SY:      l = 6'b100001;
            FL:      l = ph ? 6'b001001 : 6'b000000;
            default: l = 6'b100100;
        endcase
        return l;
    endfunction

    function automatic logic [3:0] tens(logic [6:0] r);
        return 4'(r / 7'd10);
    endfunction

    function automatic logic [3:0] ones(logic [6:0] r);
        return 4'(r % 7'd10);
    endfunction

    always_comb begin
        state_n = state;
        rem_n   = rem;
        phase_n = phase;
        if (tick) begin
            unique case (state)
                MG: begin
                    // night overrides the minimum green
                    if (night || (rem == 7'd0 && (is_car || ped))) begin
                        state_n = MY;
                        rem_n   = YEL_L;
                    end else if (rem != 7'd0) begin
                        rem_n = rem - 7'd1;
                    end
                end
                MY: begin
                    if (rem <= 7'd1) begin
                        state_n = ARA;
                        rem_n   = RED_L;
                    end else begin
                        rem_n = rem - 7'd1;
                    end
                end
                ARA: begin
                    if (rem <= 7'd1) begin
                        state_n = night ? FL : SG;
                        rem_n   = night ? 7'd0 : SIDE_L;
                    end else begin
                        rem_n = rem - 7'd1;
                    end
                end
                SG: begin
                    if (rem <= 7'd1 || !is_car) begin
                        state_n = SY;
                        rem_n   = YEL_L;
                    end else begin
                        rem_n = rem - 7'd1;
                    end
                end
                SY: begin
                    if (rem <= 7'd1) begin
                        state_n = ARB;
                        rem_n   = RED_L;
                    end else begin
                        rem_n = rem - 7'd1;
                    end
                end
                ARB: begin
                    if (rem <= 7'd1) begin
                        state_n = MG;
                        rem_n   = MAIN_L;
                    end else begin
                        rem_n = rem - 7'd1;
                    end
                end
                FL: begin
                    if (!night) begin
                        state_n = ARB;
                        rem_n   = RED_L;
                        phase_n = 1'b0;
                    end else begin
                        phase_n = ~phase;
                    end
                end
                default: begin
                    state_n = MG;
                    rem_n   = MAIN_L;
                    phase_n = 1'b0;
                end
            endcase
        end
        // clearing on side-green entry beats a coincident request
        ped_n = ped | ped_req;
        if (state_n == SG && state != SG) ped_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MG;
            rem   <= MAIN_L;
            ped   <= 1'b0;
            phase <= 1'b0;
            LEDR  <= 6'b010100;
            num1  <= tens(MAIN_L);
            num0  <= ones(MAIN_L);
        end else begin
            state <= state_n;
            rem   <= rem_n;
            ped   <= ped_n;
            phase <= phase_n;
            LEDR  <= lamps(state_n, phase_n);
            num1  <= tens(rem_n);
            num0  <= ones(rem_n);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: directed phase walk-throughs plus
// randomized traffic checked every clock against a behavioural model.
module tb_traffic_ctrl_param;

    localparam int MAIN = 5;
    localparam int SIDE = 4;
    localparam int YEL  = 2;
    localparam int RED  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       is_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [5:0] LEDR;
    logic [3:0] num1, num0;
    logic [2:0] state_o;

    int  n_assert = 0;
    int  n_fail = 0;
    int  cyc = 0;
    bit  tick_en = 1'b1;
    bit  rnd_tick = 1'b0;
    bit  last_tick = 1'b0;

    int  m_st = 0;
    int  m_rem = MAIN;
    bit  m_ped = 1'b0;
    bit  m_ph = 1'b0;

    traffic_ctrl_param #(
        .MAIN_MIN_T(MAIN), .SIDE_MAX_T(SIDE),
        .YELLOW_T(YEL), .ALL_RED_T(RED)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .is_car(is_car),
        .ped_req(ped_req), .night(night), .LEDR(LEDR),
        .num1(num1), .num0(num0), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Phase ids: 0 MG, 1 MY, 2 ARA, 3 SG, 4 SY, 5 ARB, 6 FL
    function automatic int dur(int s);
        case (s)
            0:       return MAIN;
            3:       return SIDE;
            1, 4:    return YEL;
            6:       return 0;
            default: return RED;
        endcase
    endfunction

    function automatic int succ(int s, bit nt);
        case (s)
            1:       return 2;
            2:       return nt ? 6 : 3;
            4:       return 5;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] exp_led(int s, bit ph);
        case (s)
            0:       return 6'b010100;
            1:       return 6'b001100;
            3:       return 6'b100010;
            4:       return 6'b100001;
            6:       return ph ? 6'b001001 : 6'b000000;
            default: return 6'b100100;
        endcase
    endfunction

    task automatic model_clk(bit r, bit t, bit car, bit pr, bit nt);
        int prev;
        prev = m_st;
        if (r) begin
            m_st = 0; m_rem = MAIN; m_ped = 0; m_ph = 0;
            return;
        end
        if (t) begin
            if (m_st == 0) begin
                if (nt || (m_rem == 0 && (car || m_ped))) begin
                    m_st = 1; m_rem = dur(1);
                end else if (m_rem > 0) m_rem--;
            end else if (m_st == 3) begin
                if (m_rem == 1 || !car) begin
                    m_st = 4; m_rem = dur(4);
                end else m_rem--;
            end else if (m_st == 6) begin
                if (!nt) begin
                    m_st = 5; m_rem = dur(5); m_ph = 0;
                end else m_ph = !m_ph;
            end else if (m_rem > 1) begin
                m_rem--;
            end else begin
                m_st = succ(m_st, nt); m_rem = dur(m_st);
            end
        end
        m_ped = m_ped | pr;
        if (m_st == 3 && prev != 3) m_ped = 0;
    endtask

    task automatic step();
        bit t;
        t = rnd_tick ? ($urandom_range(0, 2) == 0)
                     : (tick_en && (cyc % 3 == 2));
        tick = t;
        @(posedge clk);
        model_clk(rst, t, is_car, ped_req, night);
        last_tick = t;
        cyc++;
        #1;
    endtask

    task automatic tick_n(input int n);
        int k;
        k = 0;
        for (int i = 0; i < n * 8 + 8 && k < n; i++) begin
            step();
            if (last_tick) k++;
        end
    endtask

    task automatic goto_state(input int s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick_n(1);
            ok = (state_o == 3'(s));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        n_assert++;
        if (state_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", state_o);
        end
        n_assert++;
        if (LEDR !== 6'b010100) begin
            n_fail++; $display("FAIL reset_led: got %b want 010100", LEDR);
        end
        n_assert++;
        if ({num1, num0} !== 8'h05) begin
            n_fail++; $display("FAIL reset_disp: got %h want 05", {num1, num0});
        end
    endtask

    task automatic test_idle();
        is_car = 1'b0;
        tick_n(5);
        n_assert++;
        if ({state_o, num1, num0} !== {3'd0, 8'h00}) begin
            n_fail++;
            $display("FAIL idle_zero: got st %0d %h want st 0 00", state_o, {num1, num0});
        end
        tick_n(6);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd0, 6'b010100, 8'h00}) begin
            n_fail++;
            $display("FAIL idle_hold: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_en = 1'b0;
        is_car = 1'b1;
        repeat (10) step();
        is_car = 1'b0;
        tick_en = 1'b1;
        tick_n(1);
        n_assert++;
        if ({state_o, num1, num0} !== {3'd0, 8'h00}) begin
            n_fail++; $display("FAIL idle_stretch: got st %0d want 0", state_o);
        end
    endtask

    task automatic test_cycle();
        is_car = 1'b1;
        tick_n(1);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd1, 6'b001100, 8'h02}) begin
            n_fail++;
            $display("FAIL cyc_my: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(2);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd2, 6'b100100, 8'h01}) begin
            n_fail++;
            $display("FAIL cyc_ara: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(1);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd3, 6'b100010, 8'h04}) begin
            n_fail++;
            $display("FAIL cyc_sg: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(4);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd4, 6'b100001, 8'h02}) begin
            n_fail++;
            $display("FAIL cyc_sy: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(2);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd5, 6'b100100, 8'h01}) begin
            n_fail++;
            $display("FAIL cyc_arb: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(1);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd0, 6'b010100, 8'h05}) begin
            n_fail++;
            $display("FAIL cyc_mg: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
    endtask

    task automatic test_gapout();
        bit ok;
        goto_state(3, ok);
        n_assert++;
        if (!ok) begin
            n_fail++; $display("FAIL gap_reach: got st %0d want 3", state_o);
        end
        tick_n(1);
        n_assert++;
        if ({state_o, num1, num0} !== {3'd3, 8'h03}) begin
            n_fail++; $display("FAIL gap_sg03: got st %0d %h", state_o, {num1, num0});
        end
        is_car = 1'b0;
        tick_n(1);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd4, 6'b100001, 8'h02}) begin
            n_fail++;
            $display("FAIL gap_sy: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
    endtask

    task automatic test_ped();
        bit ok;
        goto_state(0, ok);
        tick_n(2);
        n_assert++;
        if (!ok || {state_o, num1, num0} !== {3'd0, 8'h03}) begin
            n_fail++; $display("FAIL ped_mg3: got st %0d %h", state_o, {num1, num0});
        end
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        tick_n(3);
        n_assert++;
        if ({state_o, num1, num0} !== {3'd0, 8'h00}) begin
            n_fail++; $display("FAIL ped_min: got st %0d %h", state_o, {num1, num0});
        end
        tick_n(1);
        n_assert++;
        if (state_o !== 3'd1) begin
            n_fail++; $display("FAIL ped_exit: got st %0d want 1", state_o);
        end
        goto_state(3, ok);
        goto_state(0, ok);
        tick_n(MAIN + 3);
        n_assert++;
        if (!ok || {state_o, num1, num0} !== {3'd0, 8'h00}) begin
            n_fail++; $display("FAIL ped_clear: got st %0d want 0", state_o);
        end
    endtask

    task automatic test_night();
        bit ok;
        is_car = 1'b1;
        goto_state(1, ok);
        is_car = 1'b0;
        goto_state(0, ok);
        tick_n(1);
        n_assert++;
        if (!ok || {state_o, num1, num0} !== {3'd0, 8'h04}) begin
            n_fail++; $display("FAIL nt_mg4: got st %0d %h", state_o, {num1, num0});
        end
        night = 1'b1;
        tick_n(1);
        n_assert++;
        if ({state_o, num1, num0} !== {3'd1, 8'h02}) begin
            n_fail++; $display("FAIL nt_my: got st %0d %h", state_o, {num1, num0});
        end
        tick_n(3);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd6, 6'b000000, 8'h00}) begin
            n_fail++;
            $display("FAIL nt_fl: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(1);
        n_assert++;
        if (LEDR !== 6'b001001) begin
            n_fail++; $display("FAIL nt_flash1: got %b want 001001", LEDR);
        end
        tick_n(1);
        n_assert++;
        if (LEDR !== 6'b000000) begin
            n_fail++; $display("FAIL nt_flash0: got %b want 000000", LEDR);
        end
        night = 1'b0;
        tick_n(1);
        n_assert++;
        if ({state_o, LEDR, num1, num0} !== {3'd5, 6'b100100, 8'h01}) begin
            n_fail++;
            $display("FAIL nt_arb: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(1);
        n_assert++;
        if ({state_o, num1, num0} !== {3'd0, 8'h05}) begin
            n_fail++; $display("FAIL nt_mg: got st %0d %h", state_o, {num1, num0});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        is_car = 1'b1;
        goto_state(4, ok);
        is_car = 1'b0;
        ped_req = 1'b1;
        step();
        rst = 1'b1;
        ped_req = 1'b0;
        step();
        rst = 1'b0;
        n_assert++;
        if (!ok || {state_o, LEDR, num1, num0} !== {3'd0, 6'b010100, 8'h05}) begin
            n_fail++;
            $display("FAIL rmid: got st %0d %b %h", state_o, LEDR, {num1, num0});
        end
        tick_n(MAIN + 2);
        n_assert++;
        if ({state_o, num1, num0} !== {3'd0, 8'h00}) begin
            n_fail++; $display("FAIL rmid_ped: got st %0d want 0", state_o);
        end
    endtask

    task automatic test_random();
        rnd_tick = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) is_car = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) night = ~night;
            ped_req = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 399) == 0);
            step();
            n_assert++;
            if (state_o !== 3'(m_st)) begin
                n_fail++; $display("FAIL rnd_state @%0d: got %0d want %0d", i, state_o, m_st);
            end
            n_assert++;
            if (LEDR !== exp_led(m_st, m_ph)) begin
                n_fail++;
                $display("FAIL rnd_led @%0d: got %b want %b", i, LEDR, exp_led(m_st, m_ph));
            end
            n_assert++;
            if ({num1, num0} !== {4'(m_rem / 10), 4'(m_rem % 10)}) begin
                n_fail++;
                $display("FAIL rnd_disp @%0d: got %h want %0d", i, {num1, num0}, m_rem);
            end
        end
        rnd_tick = 1'b0;
        rst = 1'b0;
        ped_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_cycle();
        test_gapout();
        test_ped();
        test_night();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
- Parametrised two-road intersection controller: main road and side road.
- Timing runs on an external `tick` strobe (1 Hz enable) rather than on raw clock cycles.
- Provides:
  - configurable phase durations;
  - all-red clearance;
  - side-road gap-out;
  - latched pedestrian request;
  - night flashing mode;
  - two-digit BCD countdown for the seven-segment display drivers.

Parameters:
- MAIN_MIN_T, 60: minimum main-green ticks. Legal range 1..99.
- SIDE_MAX_T, 30: maximum side-green ticks. Legal range 1..99.
- YELLOW_T, 3: yellow ticks, both roads. Legal range 1..99.
- ALL_RED_T, 2: all-red clearance ticks. Legal range 1..99.

Ports:
- clk  in  1  system clock; the block uses one clock only.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide timing strobe; all timing advances only on clk edges where tick=1.
- is_car  in  1  side-road vehicle sensor, level.
- ped_req  in  1  pedestrian crossing request, pulse or level.
- night  in  1  night mode request, level.
- LEDR  out  6  lamp drive, high = lit:
  - [5] main red, [4] main green, [3] main yellow;
  - [2] side red, [1] side green, [0] side yellow.
- num1  out  4  BCD tens digit of the remaining count.
- num0  out  4  BCD ones digit of the remaining count.
- state_o  out  3  current state encoding, for debug and verification.

Behaviour:
- Clocking and registers:
  - Single clock `clk`; reset `rst` is synchronous and active-high.
  - All outputs are registered and update on the same clk edge as the state register, with no extra lag.
- States and encodings (state_o / LEDR):
  - MG = 0 (LEDR 010100)
  - MY = 1 (LEDR 001100)
  - ARA = 2 (LEDR 100100)
  - SG = 3 (LEDR 100010)
  - SY = 4 (LEDR 100001)
  - ARB = 5 (LEDR 100100)
  - FL = 6 (LEDR 000000 or 001001 by flash phase)
- Reset values:
  - state MG, rem = MAIN_MIN_T;
  - LEDR = 010100;
  - num1:num0 = BCD(MAIN_MIN_T), i.e. 6:0 at default;
  - ped latch = 0, flash phase = 0.
- Remaining counter `rem`:
  - 7-bit; loaded with the new state's duration on every state entry;
  - num1:num0 always equal the BCD of rem.
- Timed states MY, ARA, SY, ARB:
  - On a tick with rem > 1: decrement rem.
  - On a tick with rem == 1: advance to the next state.
  - Each of these states therefore lasts exactly its duration in ticks.
- Transition order: MY -> ARA; ARA -> SG, or FL if night=1 at that tick; SY -> ARB; ARB -> MG.
- MG:
  - Ticks decrement rem down to 0, after which rem holds at 0 (display 00).
  - Exit to MY on a tick when rem == 0 and (is_car or the ped latch is set).
  - night=1 on any MG tick forces MY immediately, overriding the minimum time.
- SG (load SIDE_MAX_T):
  - On a tick with rem == 1 or is_car == 0 (gap-out), go to SY.
  - Otherwise decrement rem.
- FL:
  - Display 00; the flash phase toggles each tick; LEDR follows the phase.
  - On a tick with night=0, go to ARB with phase cleared.
- Ped latch:
  - Set on any clk with ped_req=1, regardless of tick.
  - Cleared on entry to SG.
  - If set and clear coincide, clear wins.
- Simultaneous events:
  - In MG, night takes priority over is_car/ped (both lead to MY).
  - tick=0 freezes all timing and state; sensor inputs are sampled only on ticks, except ped_req.
- Reset asserted mid-phase returns to the reset values on the next clk edge, regardless of tick.

Test Plan:
- Bench setup: parameters MAIN_MIN_T=5, SIDE_MAX_T=4, YELLOW_T=2, ALL_RED_T=1; tick every 3rd clk.
- Reset, then hold is_car=0: after 5 ticks num1:num0 = 0:0 and state stays MG (LEDR 010100) indefinitely; tick=0 stretches produce no change.
- Raise is_car after MG reaches 00: next tick gives MY (LEDR 001100, display 02); 2 ticks later ARA (100100, 01); 1 tick later SG (100010, 04); with is_car held, 4 ticks later SY; then ARB; then MG with display 05.
- Gap-out: in SG with display 03, drop is_car -> next tick gives SY (100001, display 02).
- Single-clk ped_req pulse during MG with rem=3 and is_car=0: MG completes its minimum time, then goes to MY on the first tick at rem 0; the latch reads 0 after SG entry.
- night=1 in MG at rem=4 -> MY, then ARA, then FL. LEDR alternates 001001/000000 per tick. Drop night -> ARB for 1 tick, then MG with display 05.
- rst=1 for one clk during SY -> next edge gives state_o=0, LEDR 010100, display 0:5, ped latch 0.
